// File: rtl/fpu_pkg.sv
// Shared FPU-cluster types and constants used by the floor arbiter slice.
package fpu_pkg;

   localparam int unsigned FLOAT_W   = 32;
   localparam int unsigned FLOOR_LAT = 2;
   // Tag width covers the largest supported requester count (8).
   localparam int unsigned ID_W      = 3;

   typedef struct packed {
      logic [ID_W-1:0]    id;
      logic [FLOAT_W-1:0] data;
   } resp_entry_t;

endpackage

// File: rtl/floor_arbiter_if.sv
// Issue/response bundle between the FPU cluster requesters and floor_arbiter.
interface floor_arbiter_if
   import fpu_pkg::*;
#(
   parameter int unsigned NREQ = 4
);

   localparam int unsigned RID_W = $clog2(NREQ);

   logic [NREQ-1:0]         req_valid;
   logic [NREQ-1:0]         req_ready;
   logic [FLOAT_W*NREQ-1:0] req_op;
   logic                    resp_valid;
   logic                    resp_ready;
   logic [FLOAT_W-1:0]      resp_data;
   logic [RID_W-1:0]        resp_id;
   logic                    busy;

   modport master (
      output req_valid, req_op, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_id, busy
   );

   modport slave (
      input  req_valid, req_op, resp_ready,
      output req_ready, resp_valid, resp_data, resp_id, busy
   );

endinterface

// File: rtl/floor.sv
// Two-stage pipelined float32 floor: stage 1 truncates toward zero, stage 2
// adds one unit in the last integer place for negative inputs with a fraction.
module floor
   import fpu_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [FLOAT_W-1:0] op,
   output logic [FLOAT_W-1:0] result
);

   localparam logic [7:0]         EXP_BIAS  = 8'd127;
   localparam logic [7:0]         EXP_INT   = 8'd150;
   localparam logic [FLOAT_W-1:0] NEG_ONE   = 32'hBF80_0000;
   localparam logic [22:0]        FRAC_ALL  = 23'h7F_FFFF;

   logic [FLOAT_W-1:0] trunc_d, trunc_q;
   logic [FLOAT_W-1:0] inc_d, inc_q;
   logic [FLOAT_W-1:0] res_d, res_q;
   logic [22:0]        frac_mask_c;

   // Stage 1: clear fractional mantissa bits, remember the round-down step.
   always_comb begin
      frac_mask_c = '0;
      trunc_d     = op;
      inc_d       = '0;
      if (op[30:23] < EXP_BIAS) begin
         if (op[31] && (op[30:0] != '0)) trunc_d = NEG_ONE;
         else                            trunc_d = {op[31], 31'd0};
      end else if (op[30:23] < EXP_INT) begin
         frac_mask_c = FRAC_ALL >> (op[30:23] - EXP_BIAS);
         trunc_d     = {op[31:23], op[22:0] & ~frac_mask_c};
         if (op[31] && ((op[22:0] & frac_mask_c) != '0))
            inc_d = {9'd0, frac_mask_c} + 32'd1;
      end
   end

   // Stage 2: magnitude increment; a mantissa carry rolls into the exponent.
   always_comb begin
      res_d = trunc_q + inc_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         trunc_q <= '0;
         inc_q   <= '0;
         res_q   <= '0;
      end else begin
         trunc_q <= trunc_d;
         inc_q   <= inc_d;
         res_q   <= res_d;
      end
   end

   assign result = res_q;

endmodule

// File: rtl/floor_resp_fifo.sv
// Response FIFO with a registered head entry and registered count/flags.
module floor_resp_fifo
   import fpu_pkg::*;
#(
   parameter int unsigned DEPTH = 4
)
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  resp_entry_t                din,
   input  logic                       pop,
   output resp_entry_t                head,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   resp_entry_t      mem_q [DEPTH];
   resp_entry_t      mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             empty_q, empty_d;
   logic             full_q, full_d;
   resp_entry_t      head_q, head_d;
   logic             do_push_c;
   logic             do_pop_c;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
   endfunction

   assign do_push_c = push & ~full_q;
   assign do_pop_c  = pop & ~empty_q;

   // Head is looked up from the next-state image so a push into an empty
   // FIFO is visible on the following cycle.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push_c) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop_c) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
      empty_d = (count_d == '0);
      full_d  = (count_d == CNT_W'(DEPTH));
      head_d  = mem_d[rd_ptr_d];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         head_q   <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
         head_q   <= head_d;
      end
   end

   assign head  = head_q;
   assign count = count_q;
   assign empty = empty_q;
   assign full  = full_q;

endmodule

// File: rtl/floor_arbiter.sv
// Round-robin arbiter sharing one floor unit among NREQ requesters, with
// credit-based back-pressure and in-order tagged responses.
// Optional macro FLOOR_ARB_PERF_EN adds perf_issued/perf_stall counters.
module floor_arbiter
   import fpu_pkg::*;
#(
   parameter int unsigned NREQ       = 4,
   parameter int unsigned FIFO_DEPTH = 4
)
(
   input  logic          clk,
   input  logic          reset,
   floor_arbiter_if.slave bus
`ifdef FLOOR_ARB_PERF_EN
   ,
   output logic [31:0]   perf_issued,
   output logic [31:0]   perf_stall
`endif
);

   localparam int unsigned PTR_W = $clog2(NREQ);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned OP_W  = FLOAT_W * NREQ;
   localparam int unsigned OFS_W = $clog2(OP_W);

   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic               iss_v_q, iss_v_d;
   logic [PTR_W-1:0]   iss_id_q, iss_id_d;
   logic [FLOAT_W-1:0] iss_op_q, iss_op_d;
   logic               d1_v_q, d1_v_d;
   logic [PTR_W-1:0]   d1_id_q, d1_id_d;
   logic               d2_v_q, d2_v_d;
   logic [PTR_W-1:0]   d2_id_q, d2_id_d;

   logic               gnt_found_c;
   logic [PTR_W-1:0]   gnt_idx_c;
   logic [OFS_W-1:0]   op_ofs_c;
   logic               can_issue_c;
   logic               accept_c;
   logic               pop_c;
   int unsigned        occ_c;

   logic [FLOAT_W-1:0] floor_result;
   resp_entry_t        fifo_din;
   resp_entry_t        fifo_head;
   logic [CNT_W-1:0]   fifo_count;
   logic               fifo_empty;
   logic               fifo_full;

   function automatic logic [PTR_W-1:0] rr_inc(input logic [PTR_W-1:0] p);
      return (32'(p) == NREQ - 1) ? '0 : p + PTR_W'(1);
   endfunction

   // First valid requester at or after rr_ptr, wrapping modulo NREQ.
   always_comb begin : arb
      int unsigned pos;
      gnt_found_c = 1'b0;
      gnt_idx_c   = '0;
      pos         = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         pos = 32'(rr_ptr_q) + k;
         if (pos >= NREQ) pos = pos - NREQ;
         if (!gnt_found_c && bus.req_valid[PTR_W'(pos)]) begin
            gnt_found_c = 1'b1;
            gnt_idx_c   = PTR_W'(pos);
         end
      end
   end

   // Credit ignores a same-cycle pop, trading a bubble for a short path.
   always_comb begin
      occ_c = 32'(fifo_count) + 32'(iss_v_q) + 32'(d1_v_q) + 32'(d2_v_q);
   end

   assign can_issue_c   = occ_c < FIFO_DEPTH;
   assign accept_c      = gnt_found_c & can_issue_c;
   assign op_ofs_c      = OFS_W'(32'(gnt_idx_c) * FLOAT_W);
   assign bus.req_ready = accept_c ? (NREQ'(1'b1) << gnt_idx_c) : '0;

   always_comb begin
      iss_v_d  = accept_c;
      iss_id_d = iss_id_q;
      iss_op_d = iss_op_q;
      rr_ptr_d = rr_ptr_q;
      if (accept_c) begin
         iss_id_d = gnt_idx_c;
         iss_op_d = bus.req_op[op_ofs_c +: FLOAT_W];
         rr_ptr_d = rr_inc(gnt_idx_c);
      end
      d1_v_d  = iss_v_q;
      d1_id_d = iss_id_q;
      d2_v_d  = d1_v_q;
      d2_id_d = d1_id_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rr_ptr_q <= '0;
         iss_v_q  <= 1'b0;
         iss_id_q <= '0;
         iss_op_q <= '0;
         d1_v_q   <= 1'b0;
         d1_id_q  <= '0;
         d2_v_q   <= 1'b0;
         d2_id_q  <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         iss_v_q  <= iss_v_d;
         iss_id_q <= iss_id_d;
         iss_op_q <= iss_op_d;
         d1_v_q   <= d1_v_d;
         d1_id_q  <= d1_id_d;
         d2_v_q   <= d2_v_d;
         d2_id_q  <= d2_id_d;
      end
   end

   floor u_floor (
      .clk    (clk),
      .reset  (reset),
      .op     (iss_op_q),
      .result (floor_result)
   );

   always_comb begin
      fifo_din      = '0;
      fifo_din.id   = ID_W'(d2_id_q);
      fifo_din.data = floor_result;
   end

   assign pop_c = ~fifo_empty & bus.resp_ready;

   floor_resp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (d2_v_q),
      .din   (fifo_din),
      .pop   (pop_c),
      .head  (fifo_head),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign bus.resp_valid = ~fifo_empty;
   assign bus.resp_data  = fifo_head.data;
   assign bus.resp_id    = fifo_head.id[PTR_W-1:0];
   assign bus.busy       = iss_v_q | d1_v_q | d2_v_q | ~fifo_empty;

   a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset)
      d2_v_q |-> !fifo_full);
   a_head_id_in_range: assert property (@(posedge clk) disable iff (!reset)
      !fifo_empty |-> (32'(fifo_head.id) < NREQ));

`ifdef FLOOR_ARB_PERF_EN
   logic [31:0] perf_issued_q, perf_issued_d;
   logic [31:0] perf_stall_q, perf_stall_d;

   // Free-running wrap-around event counters.
   always_comb begin
      perf_issued_d = perf_issued_q + 32'(accept_c);
      perf_stall_d  = perf_stall_q + 32'((|bus.req_valid) & ~can_issue_c);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         perf_issued_q <= '0;
         perf_stall_q  <= '0;
      end else begin
         perf_issued_q <= perf_issued_d;
         perf_stall_q  <= perf_stall_d;
      end
   end

   assign perf_issued = perf_issued_q;
   assign perf_stall  = perf_stall_q;
`endif

endmodule
